// File: rtl/add_pkg.sv
// add_pkg: shared defaults and types for the registered adder stage.
package add_pkg;
  localparam int AW_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int CW_DEF = 16;
  typedef logic [AW_DEF-1:0] opnd_t;
  typedef logic [AW_DEF:0] sum_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_state_t;
endpackage

// File: rtl/add_fifo.sv
// add_fifo: power-of-2 result FIFO with occupancy counter and registered head.
module add_fifo
  import add_pkg::*;
#(
  parameter int W = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] occ;
  occ_state_t state;
  always_comb state = occ == '0 ? EMPTY : occ == (PW+1)'(DEPTH) ? FULL : PARTIAL;
  assign full = state == FULL;
  assign empty = state == EMPTY;
  // Zero the head while empty so reset and drained states show a clean 0.
  assign rdata = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wdata;
endmodule

// File: rtl/add_stage.sv
// add_stage: registered AW-bit adder with valid/ready on both sides and a result FIFO.
module add_stage
  import add_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_a,
  input  logic [AW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   out_sum,
  output logic          out_carry,
  input  logic          clr,
  output logic [CW-1:0] txn_count
);
  logic full, empty, push, pop;
  logic [AW:0] sum;
  assign in_ready = rst_n && !full;
  assign out_valid = !empty;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign sum = {1'b0, in_a} + {1'b0, in_b};
  assign out_carry = out_sum[AW];
  add_fifo #(.W(AW + 1), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .wdata(sum),
    .rdata(out_sum),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) txn_count <= '0;
    else if (clr) txn_count <= '0;
    else if (pop) txn_count <= txn_count + CW'(1);
endmodule

// File: tb/tb_add_stage.sv
// tb_add_stage: directed and random checks of add_stage with DEPTH=4, CW=4.
module tb_add_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, clr = 0;
  logic in_ready, out_valid, out_carry;
  logic [3:0] in_a = 0, in_b = 0, txn_count;
  logic [4:0] out_sum;
  int pass_cnt = 0, total = 0;

  add_stage #(.AW(4), .DEPTH(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .clr(clr), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1; in_a = a; in_b = b;
    step;
    in_valid = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0d want 0", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0d want 0", out_valid); else pass_cnt++;
    total++; if (out_sum !== 5'd0) $display("FAIL rst_out_sum got %0d want 0", out_sum); else pass_cnt++;
    total++; if (txn_count !== 4'd0) $display("FAIL rst_txn got %0d want 0", txn_count); else pass_cnt++;
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got %0d want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic;
    out_ready = 1; in_valid = 1; in_a = 7; in_b = 9;
    step;
    in_a = 15; in_b = 15;
    total++; if (out_valid !== 1'b1 || out_sum !== 5'd16) $display("FAIL basic_16 got v=%0d s=%0d want v=1 s=16", out_valid, out_sum); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL basic_c16 got %0d want 1", out_carry); else pass_cnt++;
    step;
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_sum !== 5'd30) $display("FAIL basic_30 got v=%0d s=%0d want v=1 s=30", out_valid, out_sum); else pass_cnt++;
    total++; if (out_carry !== 1'b1) $display("FAIL basic_c30 got %0d want 1", out_carry); else pass_cnt++;
    step;
    total++; if (out_valid !== 1'b0) $display("FAIL basic_drain got %0d want 0", out_valid); else pass_cnt++;
    total++; if (txn_count !== 4'd2) $display("FAIL basic_txn got %0d want 2", txn_count); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [4:0] exp [5] = '{5'd3, 5'd7, 5'd11, 5'd15, 5'd18};
    clr = 1; step; clr = 0;
    out_ready = 0;
    push_one(1, 2); push_one(3, 4); push_one(5, 6); push_one(7, 8);
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full got in_ready=%0d want 0", in_ready); else pass_cnt++;
    in_valid = 1; in_a = 9; in_b = 9;
    step; step;
    total++; if (in_ready !== 1'b0 || out_sum !== 5'd3) $display("FAIL bp_hold got r=%0d s=%0d want r=0 s=3", in_ready, out_sum); else pass_cnt++;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_sum !== exp[i]) $display("FAIL bp_order%0d got v=%0d s=%0d want v=1 s=%0d", i, out_valid, out_sum, exp[i]); else pass_cnt++;
      step;
      if (i == 1) in_valid = 0;
    end
    total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0d want 0", out_valid); else pass_cnt++;
    total++; if (txn_count !== 4'd5) $display("FAIL bp_txn got %0d want 5", txn_count); else pass_cnt++;
    out_ready = 0;
  endtask

  task automatic test_push_full;
    logic [4:0] exp [3] = '{5'd4, 5'd6, 5'd8};
    push_one(1, 1); push_one(2, 2); push_one(3, 3); push_one(4, 4);
    total++; if (in_ready !== 1'b0) $display("FAIL pf_full got in_ready=%0d want 0", in_ready); else pass_cnt++;
    in_valid = 1; in_a = 5; in_b = 5; out_ready = 1;
    step;
    in_valid = 0; out_ready = 0;
    total++; if (in_ready !== 1'b1 || out_sum !== 5'd4) $display("FAIL pf_onepop got r=%0d s=%0d want r=1 s=4", in_ready, out_sum); else pass_cnt++;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_sum !== exp[i]) $display("FAIL pf_drain%0d got v=%0d s=%0d want v=1 s=%0d", i, out_valid, out_sum, exp[i]); else pass_cnt++;
      step;
    end
    total++; if (out_valid !== 1'b0) $display("FAIL pf_nopush got %0d want 0", out_valid); else pass_cnt++;
    out_ready = 0;
  endtask

  task automatic test_reset_mid;
    clr = 1; step; clr = 0;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_a = 4'(i); in_b = 4'(i + 1);
      step;
    end
    in_valid = 0;
    step;
    out_ready = 0;
    push_one(2, 3); push_one(4, 5); push_one(6, 7);
    total++; if (txn_count !== 4'd5 || out_valid !== 1'b1 || out_sum !== 5'd5) $display("FAIL rm_setup got t=%0d v=%0d s=%0d want t=5 v=1 s=5", txn_count, out_valid, out_sum); else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || txn_count !== 4'd0 || out_sum !== 5'd0) $display("FAIL rm_async got v=%0d t=%0d s=%0d want 0 0 0", out_valid, txn_count, out_sum); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL rm_in_ready got %0d want 0", in_ready); else pass_cnt++;
    rst_n = 1;
    step;
    total++; if (out_valid !== 1'b0 || out_sum !== 5'd0) $display("FAIL rm_stale got v=%0d s=%0d want 0 0", out_valid, out_sum); else pass_cnt++;
  endtask

  task automatic test_clear;
    out_ready = 0;
    push_one(1, 1); push_one(2, 2); push_one(3, 3); push_one(4, 4);
    out_ready = 1;
    step; step;
    total++; if (txn_count !== 4'd2) $display("FAIL clr_pre got %0d want 2", txn_count); else pass_cnt++;
    clr = 1;
    step;
    clr = 0;
    total++; if (txn_count !== 4'd0 || out_sum !== 5'd8) $display("FAIL clr_win got t=%0d s=%0d want t=0 s=8", txn_count, out_sum); else pass_cnt++;
    step;
    total++; if (txn_count !== 4'd1) $display("FAIL clr_next got %0d want 1", txn_count); else pass_cnt++;
    out_ready = 0;
  endtask

  task automatic test_wrap;
    clr = 1; step; clr = 0;
    out_ready = 1; in_valid = 1; in_a = 3; in_b = 4;
    repeat (16) step;
    in_valid = 0;
    total++; if (txn_count !== 4'd15) $display("FAIL wrap_15 got %0d want 15", txn_count); else pass_cnt++;
    step;
    total++; if (txn_count !== 4'd0) $display("FAIL wrap_0 got %0d want 0", txn_count); else pass_cnt++;
    out_ready = 0;
  endtask

  task automatic test_random;
    logic [4:0] q [$];
    int sent = 0, cyc = 0;
    while ((sent < 200 || q.size() != 0) && cyc < 5000) begin
      in_valid = sent < 200 ? 1'($urandom_range(0, 1)) : 1'b0;
      in_a = 4'($urandom); in_b = 4'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0 || out_sum !== q[0]) $display("FAIL rnd_sum got %0d want %0d (queued %0d)", out_sum, q.size() ? q[0] : 5'd0, q.size());
        else pass_cnt++;
        if (q.size() != 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(5'(in_a) + 5'(in_b));
        sent++;
      end
      step;
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    total++; if (cyc >= 5000) $display("FAIL rnd_timeout got sent=%0d pending=%0d want completion", sent, q.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_push_full;
    test_reset_mid;
    test_clear;
    test_wrap;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/add_stage.md
# add_stage

Registered 4-bit adder stage with valid/ready handshakes on both sides and a small result FIFO. It consumes operand pairs (`a`, `b`) from the random stimulus driver and produces 5-bit sums for a downstream checker or scoreboard. It replaces the bench's untimed `a + b` task with a clocked, back-pressurable datapath. A wrapping handshake counter provides coverage bookkeeping.

## Interface
- `AW`, default 4: operand width in bits. The sum is `AW+1` bits.
- `DEPTH`, default 4: result FIFO depth. Must be a power of 2 and at least 2.
- `CW`, default 16: width of the transaction counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: operand pair is valid.
- `in_ready`, out, 1: stage can accept an operand pair.
- `in_a`, in, `AW`: operand a.
- `in_b`, in, `AW`: operand b.
- `out_valid`, out, 1: result at the FIFO head is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_sum`, out, `AW+1`: zero-extended `in_a + in_b`.
- `out_carry`, out, 1: equals `out_sum[AW]`.
- `clr`, in, 1: synchronous clear of `txn_count`.
- `txn_count`, out, `CW`: number of completed output handshakes.

## Operation
- **Accept:** an operand pair is accepted on an edge where `in_valid && in_ready`.
  - The unsigned sum `{1'b0,in_a} + {1'b0,in_b}` is written into the FIFO tail. There is no truncation.
- **Pop:** a result is popped on an edge where `out_valid && out_ready`.
- **Occupancy:** a counter tracks occupancy from 0 to `DEPTH`.
  - `full` = (occ == `DEPTH`).
  - `empty` = (occ == 0).
- **Handshake outputs:**
  - `in_ready` = `!full`. It does not depend on `out_ready`, so there is no full-pass-through.
  - `out_valid` = `!empty`.
  - `out_sum` and `out_carry` are driven from the FIFO head.
- **Simultaneous push and pop:**
  - When neither full nor empty, both happen and occupancy is unchanged.
  - When full, only the pop occurs, because `in_ready` is 0.
  - When empty, only the push occurs; the new data becomes visible the next cycle.
- **Pointers:** read and write pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`.
- **Stable output:** `out_sum` is held stable while `out_valid && !out_ready`.
- **Ignored inputs:** while `in_ready` = 0, `in_valid` has no effect, and operands present on those cycles are dropped.
- **Counter:** `txn_count` increments by 1 on each output handshake and wraps from 2^`CW`-1 to 0.
  - `clr` sets it to 0.
  - If `clr` and a handshake occur on the same edge, `clr` wins and the result is 0.
- **Control states:** EMPTY (occ=0), PARTIAL (0<occ<`DEPTH`), FULL (occ=`DEPTH`).
  - Transitions are driven by push/pop only.
  - EMPTY→FULL is impossible in one cycle when `DEPTH` ≥ 2.

## Timing
- **Reset values:**
  - While `rst_n` is low: occ, both pointers, and `txn_count` are 0; `out_valid` is 0; `out_sum` and `out_carry` are 0.
  - `in_ready` is forced to 0 while `rst_n` is low and rises combinationally after deassertion.
- **Reset mid-operation:** FIFO contents are discarded immediately, asynchronously, without waiting for a clock edge.
- **Latency:** an operand pair accepted at edge N into an empty FIFO shows `out_valid` = 1 with the correct `out_sum` after edge N.
  - This is 1 cycle of latency.
  - Throughput is 1 result per cycle when `out_ready` is held at 1.
- **Full timing:**
  - `in_ready` falls after the edge that makes occ = `DEPTH`.
  - It rises after the first edge containing a pop.
- **Combinational paths:** there are no combinational paths from inputs to outputs, except `in_ready`/`out_valid` from registered occupancy and the asynchronous reset gating.

## Structure
- **Package `add_pkg`:**
  - `AW_DEF`, `DEPTH_DEF`, `CW_DEF` localparams.
  - `typedef logic [AW_DEF-1:0] opnd_t`.
  - `typedef logic [AW_DEF:0] sum_t`.
  - `typedef enum {EMPTY, PARTIAL, FULL} occ_state_t` for debug visibility.
- **Sub-module `add_fifo`:** parameterised by width and `DEPTH`.
  - Ports: `clk`, `rst_n`, `push`, `pop`, `wdata`, `rdata`, `full`, `empty`.
- **`add_stage` itself:** instantiates `add_fifo` and contains the adder, handshake gating, and `txn_count`.

## Test plan
- **Basic sums:** `out_ready`=1; push (7,9) then (15,15) on consecutive cycles → `out_sum` = 16 with `out_carry`=1, then 30 with `out_carry`=1, each arriving 1 cycle after accept.
- **Backpressure:** `out_ready`=0; push (1,2),(3,4),(5,6),(7,8) → `in_ready`=0 after the 4th accept, and a 5th (9,9) held valid is not accepted. Then raise `out_ready` → results 3, 7, 11, 15, 18 in order.
- **Push while full:** with FIFO full, `in_valid`=1 and `out_ready`=1 for one cycle → exactly one pop, no push, occ=3, `in_ready`=1 next cycle.
- **Reset mid-stream:** 3 entries queued, `txn_count`=5; pulse `rst_n` low between edges → `out_valid`, `txn_count`, and `out_sum` go to 0 immediately, and no stale result appears after release.
- **Counter clear:** 2 results drained (`txn_count`=2); assert `clr` on the same edge as a 3rd handshake → `txn_count`=0, and the next handshake gives 1.
- **Counter wrap:** with `CW`=4, 16 handshakes → `txn_count` returns to 0. Run 200 random operand pairs with random `out_ready` → every result matches a reference adder, in order.
